// File: rtl/sched_req_arbiter.sv
// rtl/sched_req_arbiter.sv - round-robin front end sharing one schedule selector among NUM_REQ clients
// One transaction at a time: arbitrate, validate context, pulse sel_ev, await sel_tx or time out, grant.
module sched_req_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int CTX_W     = 32,
  parameter int NUM_SCHED = 3,
  parameter int TIMEOUT   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*CTX_W-1:0] req_context,
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     done_valid,
  output logic [2:0]               done_id,
  output logic [CTX_W-1:0]         done_schedule,
  output logic                     done_error,
  output logic                     busy,
  output logic                     sel_ev,
  output logic [CTX_W-1:0]         sel_context,
  input  logic                     sel_tx,
  input  logic [CTX_W-1:0]         sel_schedule,
  output logic [15:0]              err_count
);

  localparam int WCW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ISSUE,
    S_WAIT,
    S_RESP,
    S_GAP
  } state_t;

  state_t           state, state_nxt;
  logic [2:0]       rr_ptr;
  logic [2:0]       cur_id;
  logic [CTX_W-1:0] cur_ctx;
  logic [WCW-1:0]   wait_cnt;
  logic             win_found;
  logic [2:0]       win_id;
  logic [CTX_W-1:0] win_ctx;
  logic             ctx_ok;
  logic             timeout_hit;

  // Search offsets 0..NUM_REQ-1 from rr_ptr; the second compare handles wrap-around.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    win_ctx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!win_found && req[i] &&
            ((i == int'(rr_ptr) + k) || (i == int'(rr_ptr) + k - NUM_REQ))) begin
          win_found = 1'b1;
          win_id    = 3'(i);
          win_ctx   = req_context[i*CTX_W +: CTX_W];
        end
      end
    end
  end

  assign ctx_ok      = (cur_ctx != '0) && (cur_ctx <= CTX_W'(NUM_SCHED));
  assign timeout_hit = (wait_cnt == WCW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (win_found) state_nxt = S_CHECK;
      S_CHECK: state_nxt = ctx_ok ? S_ISSUE : S_RESP;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (sel_tx || timeout_hit) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_GAP;
      S_GAP:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Result fields are loaded on entry to RESP so they are valid during the grant and hold afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr        <= '0;
      cur_id        <= '0;
      cur_ctx       <= '0;
      wait_cnt      <= '0;
      sel_context   <= '0;
      done_id       <= '0;
      done_schedule <= '0;
      done_error    <= 1'b0;
      err_count     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (win_found) begin
            cur_id  <= win_id;
            cur_ctx <= win_ctx;
          end
        end
        S_CHECK: begin
          if (ctx_ok) begin
            sel_context <= cur_ctx;
          end else begin
            done_id       <= cur_id;
            done_schedule <= '0;
            done_error    <= 1'b1;
          end
        end
        S_ISSUE: wait_cnt <= '0;
        S_WAIT: begin
          if (sel_tx) begin
            done_id       <= cur_id;
            done_schedule <= sel_schedule;
            done_error    <= 1'b0;
          end else if (timeout_hit) begin
            done_id       <= cur_id;
            done_schedule <= '0;
            done_error    <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_RESP: begin
          rr_ptr <= (cur_id == 3'(NUM_REQ - 1)) ? 3'd0 : cur_id + 3'd1;
          if (done_error && (err_count != 16'hFFFF)) err_count <= err_count + 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign busy       = (state != S_IDLE);
  assign sel_ev     = (state == S_ISSUE);
  assign done_valid = (state == S_RESP);
  assign gnt        = done_valid ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << cur_id) : '0;

endmodule

// File: doc/sched_req_arbiter.md
Name: sched_req_arbiter

Overview:
- Shares one event-driven schedule selector among NUM_REQ requesters.
- Arbitrates requests round-robin, latches the winner's context and issues a one-cycle sel_ev pulse with that context.
- Waits for the selector's sel_tx / sel_schedule response, or times out, then returns the result to the winner with a grant pulse.
- Sits between the memory-access clients and the schedule selector; all logic is on posedge clk.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- CTX_W, 32, context/schedule width.
- NUM_SCHED, 3, highest valid context value (valid range 1..NUM_SCHED).
- TIMEOUT, 8, WAIT cycles allowed for sel_tx before error (≥2).

Ports:
- clk  in  1  clock, all logic posedge.
- rst  in  1  synchronous reset, active-high.
- req  in  NUM_REQ  per-requester request level.
- req_context  in  NUM_REQ*CTX_W  packed contexts; requester i uses bits [i*CTX_W +: CTX_W].
- gnt  out  NUM_REQ  one-hot, one-cycle completion pulse to the served requester.
- done_valid  out  1  result valid, coincident with gnt.
- done_id  out  3  index of the served requester.
- done_schedule  out  CTX_W  schedule returned; 0 on error.
- done_error  out  1  invalid context or timeout.
- busy  out  1  high in any state except IDLE.
- sel_ev  out  1  event pulse to the selector.
- sel_context  out  CTX_W  latched context to the selector.
- sel_tx  in  1  selector response strobe.
- sel_schedule  in  CTX_W  selector schedule, qualified by sel_tx.
- err_count  out  16  saturating count of error completions.

Behaviour:
- Reset: state=IDLE, rr_ptr=0. gnt, done_valid, done_error, sel_ev, busy all 0. done_id=0, done_schedule=0, sel_context=0, err_count=0, wait_cnt=0.
- Arbitration (IDLE only):
  - Winner is the first asserted req at or after rr_ptr, searching upward with wrap from NUM_REQ-1 to 0.
  - Latch winner index and its context in the same cycle.
  - rr_ptr <= (winner+1) mod NUM_REQ, updated at RESP.
- States:
  - IDLE: if any req → CHECK, else stay.
  - CHECK, 1 cycle:
    - Context in 1..NUM_SCHED → ISSUE.
    - Otherwise → RESP with error=1, schedule=0. The selector is not touched.
  - ISSUE, 1 cycle: sel_ev=1, sel_context=latched context. Then → WAIT with wait_cnt=0.
  - WAIT:
    - sel_tx=1 → capture sel_schedule, error=0, → RESP.
    - Else wait_cnt++. When wait_cnt reaches TIMEOUT-1 without sel_tx → RESP with error=1, schedule=0.
  - RESP, 1 cycle:
    - done_valid=1, gnt[id]=1, done_id/done_schedule/done_error driven.
    - err_count++ if error, saturating at 16'hFFFF. Update rr_ptr.
    - → GAP.
  - GAP, 1 cycle: sel_ev=0 guarantees the selector has returned to idle. → IDLE.
- sel_ev is high only in ISSUE. sel_context holds its value until the next ISSUE.
- done_* fields hold their last values outside RESP; only done_valid and gnt pulse.
- Latency: req rising in IDLE at cycle 0 → sel_ev at cycle 2 → earliest gnt at cycle 4 (sel_tx at cycle 3). Minimum back-to-back service period is 6 cycles per request.
- Requester may drop req after arbitration: the latched transaction completes and gnt still pulses. Context changes after the latch are ignored.
- sel_tx outside WAIT is ignored. sel_tx in the same cycle as the timeout expiry wins (success).
- Simultaneous requests: one winner per transaction. Others remain pending and are served in rotating order; no starvation — with all requesters asserted, each is served once per NUM_REQ transactions.
- rst mid-transaction: immediate return to reset values, no gnt for the aborted request. A pending sel_ev is cancelled in the next cycle.

Test Plan:
- Single request: req[1]=1, ctx=2, selector answers sel_tx with schedule 2 one cycle after sel_ev → sel_ev one cycle with sel_context=2; gnt=4'b0010, done_schedule=2, done_error=0, done_id=1, 4 cycles after req.
- Round-robin: req=4'b1111, contexts 1,2,3,1, selector always answers → grant order 0,1,2,3,0; done_schedule follows context.
- Invalid context: req[2]=1, ctx=0, then ctx=5 → no sel_ev; gnt[2] in RESP with done_error=1, done_schedule=0; err_count 0→1→2.
- Timeout: req[0]=1, ctx=3, sel_tx held 0 → done_error=1 exactly TIMEOUT=8 WAIT cycles after entering WAIT; sel_tx arriving afterwards is ignored.
- Request withdrawn plus reset: req[3] drops the cycle after CHECK → transaction still completes with gnt[3]. Repeat with rst pulsed during WAIT → all outputs return to 0, no gnt, next req is served from rr_ptr=0.
- Saturation: force 65536 error completions → err_count stays at 16'hFFFF.
